layer_bias_rx: RTL and testbench

Receiving end of the per-layer bias stream. Accepts 64-bit beats over valid/ready/last, each carrying two signed 32-bit biases (low word = even index). Stores them in a local register array and serves them to the convolution engine through a 1-cycle-latency read port. Reloadable per layer via a load_start pulse.

---
 rtl/layer_bias_rx.sv | 153 +++++++++++++++
 tb/tb_layer_bias_rx.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/layer_bias_rx.sv
// layer_bias_rx: receiving end of the per-layer bias stream.
// Each 64-bit beat carries two signed 32-bit biases. The low word is the even
// index and the high word is the odd index. The biases are stored raw in a
// local register array. The convolution engine reads them back through a
// read port with 1-cycle latency.
// A set can be reloaded at any time outside LOAD by pulsing load_start.
// Optional build macro: BIAS_RX_CHK_EN adds a sticky err_flag output. It flags
// a beat stream that ends early, or one whose final beat lacks bias_last.
module layer_bias_rx #(
  parameter int BIAS_NUM = 16,
  parameter int ADDR_W   = 4
) (
  input  logic              sclk,
  input  logic              s_rst_n,
  input  logic              load_start,
  input  logic [63:0]       bias_data,
  input  logic              bias_valid,
  input  logic              bias_last,
  output logic              ready,
  output logic              bias_done,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [31:0]       rd_data,
  output logic              rd_valid
`ifdef BIAS_RX_CHK_EN
  ,
  output logic              err_flag
`endif
);

  localparam int BEAT_NUM = BIAS_NUM / 2;
  localparam int CNT_W    = (BEAT_NUM > 1) ? $clog2(BEAT_NUM) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEAT_NUM - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;
  logic [CNT_W-1:0] beat_cnt_r;
  logic [31:0]      mem_r [BIAS_NUM];
  logic             start_s;
  logic             accept_s;
  logic             final_s;
  logic [31:0]      rd_word_s;

  // Decode the handshake, recognise the final beat, and choose the next state.
  always_comb begin
    state_nxt_s = state_r;
    start_s     = 1'b0;
    accept_s    = (state_r == LOAD) && bias_valid && ready;
    final_s     = accept_s && (bias_last || (beat_cnt_r == LAST_CNT));
    case (state_r)
      IDLE, DONE: begin
        start_s = load_start;
        if (load_start) begin
          state_nxt_s = LOAD;
        end else begin
          state_nxt_s = state_r;
        end
      end
      LOAD: begin
        if (final_s) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = LOAD;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Hold the state register, beat counter and registered ready/bias_done.
  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      state_r    <= IDLE;
      beat_cnt_r <= '0;
      ready      <= 1'b0;
      bias_done  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      if (start_s) begin
        beat_cnt_r <= '0;
        bias_done  <= 1'b0;
        ready      <= 1'b1;
      end else if (accept_s) begin
        beat_cnt_r <= beat_cnt_r + CNT_W'(1'b1);
        if (final_s) begin
          ready     <= 1'b0;
          bias_done <= 1'b1;
        end
      end
    end
  end

  // Write both words of each accepted beat into the bias array.
  // Reset clears the array so that a partially loaded set is discarded.
  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      for (int i = 0; i < BIAS_NUM; i++) begin
        mem_r[i] <= 32'd0;
      end
    end else begin
      for (int k = 0; k < BEAT_NUM; k++) begin
        if (accept_s && (beat_cnt_r == CNT_W'(k))) begin
          mem_r[2*k]   <= bias_data[31:0];
          mem_r[2*k+1] <= bias_data[63:32];
        end
      end
    end
  end

  // Select the addressed entry. Addresses outside the array read as zero.
  always_comb begin
    rd_word_s = 32'd0;
    for (int i = 0; i < BIAS_NUM; i++) begin
      rd_word_s = (rd_addr == ADDR_W'(i)) ? mem_r[i] : rd_word_s;
    end
  end

  // Register the read result.
  // The array is sampled before this edge's write, so the read returns the old value.
  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      rd_data  <= 32'd0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        rd_data <= rd_word_s;
      end
    end
  end

`ifdef BIAS_RX_CHK_EN
  // Sticky stream-framing error; an accepted load_start clears it.
  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      err_flag <= 1'b0;
    end else if (start_s) begin
      err_flag <= 1'b0;
    end else if (accept_s && (bias_last != (beat_cnt_r == LAST_CNT))) begin
      err_flag <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_layer_bias_rx.sv
// Self-checking bench for layer_bias_rx.
// The DUT is built with BIAS_NUM=16 and ADDR_W=5, so out-of-range reads can be exercised.
// Reads are scored against a local model of the bias array.
module tb_layer_bias_rx;

  localparam int BIAS_NUM = 16;
  localparam int ADDR_W   = 5;

  logic              sclk = 1'b0;
  logic              s_rst_n;
  logic              load_start;
  logic [63:0]       bias_data;
  logic              bias_valid;
  logic              bias_last;
  logic              ready;
  logic              bias_done;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [31:0]       rd_data;
  logic              rd_valid;
`ifdef BIAS_RX_CHK_EN
  logic              err_flag;
`endif

  typedef struct {
    int          cyc;
    int          addr;
    logic [31:0] data;
  } rd_exp_t;

  rd_exp_t     sb[$];
  logic [31:0] model_mem [BIAS_NUM];
  logic [31:0] stage     [BIAS_NUM];
  logic [31:0] set_a     [BIAS_NUM];
  logic [31:0] set_b     [BIAS_NUM];
  logic [31:0] set_c     [BIAS_NUM];
  int          checks = 0;
  int          errors = 0;
  int          cyc    = 0;

  layer_bias_rx #(.BIAS_NUM(BIAS_NUM), .ADDR_W(ADDR_W)) dut (
    .sclk       (sclk),
    .s_rst_n    (s_rst_n),
    .load_start (load_start),
    .bias_data  (bias_data),
    .bias_valid (bias_valid),
    .bias_last  (bias_last),
    .ready      (ready),
    .bias_done  (bias_done),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid)
`ifdef BIAS_RX_CHK_EN
    ,
    .err_flag   (err_flag)
`endif
  );

  always #5 sclk = ~sclk;

  // Advance one clock, then score the read port against the queue.
  task automatic step();
    rd_exp_t e;
    @(posedge sclk);
    #1;
    cyc++;
    load_start = 1'b0;
    rd_en      = 1'b0;
    checks++;
    if (sb.size() > 0 && sb[0].cyc == cyc) begin
      e = sb.pop_front();
      if (rd_valid !== 1'b1 || rd_data !== e.data) begin
        errors++;
        $display("FAIL read_addr%0d: got valid=%b data=%h, expected valid=1 data=%h",
                 e.addr, rd_valid, rd_data, e.data);
      end
    end else if (rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL rd_valid_idle: got %b, expected 0 (cycle %0d)", rd_valid, cyc);
    end
  endtask

  task automatic issue_read(input int addr);
    rd_exp_t e;
    rd_en   = 1'b1;
    rd_addr = ADDR_W'(addr);
    e.cyc   = cyc + 1;
    e.addr  = addr;
    e.data  = (addr < BIAS_NUM) ? model_mem[addr] : 32'd0;
    sb.push_back(e);
  endtask

  task automatic read_all();
    for (int i = 0; i < BIAS_NUM; i++) begin
      issue_read(i);
      step();
    end
    step();
  endtask

  task automatic check_flags(input string name, input logic exp_ready, input logic exp_done);
    checks++;
    if (ready !== exp_ready || bias_done !== exp_done) begin
      errors++;
      $display("FAIL %s: got ready=%b bias_done=%b, expected ready=%b bias_done=%b",
               name, ready, bias_done, exp_ready, exp_done);
    end
  endtask

  // Load beats 0..last_beat of stage. Optionally insert random valid gaps.
  // Optionally read the even entry of beat haz_beat in its write cycle, then again next cycle.
  task automatic load_layer(input int last_beat, input bit gaps, input int haz_beat);
    int k;
    int guard;
    int reread;
    load_start = 1'b1;
    step();
    check_flags("load_start_resp", 1'b1, 1'b0);
`ifdef BIAS_RX_CHK_EN
    checks++;
    if (err_flag !== 1'b0) begin
      errors++;
      $display("FAIL err_clear: got %b, expected 0", err_flag);
    end
`endif
    k = 0;
    guard = 0;
    reread = -1;
    while (k <= last_beat && guard < 200) begin
      guard++;
      if (reread >= 0) begin
        issue_read(reread);
        reread = -1;
      end
      bias_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      bias_data  = {stage[2*k+1], stage[2*k]};
      bias_last  = (k == last_beat);
      check_flags("ready_in_load", 1'b1, 1'b0);
      if (bias_valid) begin
        if (k == haz_beat) begin
          issue_read(2*k);
          reread = 2*k;
        end
        model_mem[2*k]   = stage[2*k];
        model_mem[2*k+1] = stage[2*k+1];
        k++;
      end
      step();
    end
    bias_valid = 1'b0;
    bias_last  = 1'b0;
    checks++;
    if (guard >= 200) begin
      errors++;
      $display("FAIL load_timeout: got %0d beats, expected %0d", k, last_beat + 1);
    end
    check_flags("done_after_last", 1'b0, 1'b1);
    if (reread >= 0) begin
      issue_read(reread);
      step();
    end
  endtask

  task automatic test_reset();
    s_rst_n = 1'b0; load_start = 1'b0; bias_valid = 1'b0; bias_last = 1'b0;
    bias_data = 64'd0; rd_en = 1'b0; rd_addr = '0;
    for (int i = 0; i < BIAS_NUM; i++) model_mem[i] = 32'd0;
    repeat (2) @(posedge sclk);
    #1;
    check_flags("reset_flags", 1'b0, 1'b0);
    checks++;
    if (rd_valid !== 1'b0 || rd_data !== 32'd0) begin
      errors++;
      $display("FAIL reset_read: got valid=%b data=%h, expected 0/0", rd_valid, rd_data);
    end
`ifdef BIAS_RX_CHK_EN
    checks++;
    if (err_flag !== 1'b0) begin
      errors++;
      $display("FAIL reset_err: got %b, expected 0", err_flag);
    end
`endif
    s_rst_n = 1'b1;
    step();
    check_flags("idle_flags", 1'b0, 1'b0);
    read_all();
  endtask

  task automatic test_nominal();
    for (int i = 0; i < BIAS_NUM; i++) stage[i] = set_a[i];
    load_layer(7, 1'b0, -1);
`ifdef BIAS_RX_CHK_EN
    checks++;
    if (err_flag !== 1'b0) begin
      errors++;
      $display("FAIL err_nominal: got %b, expected 0", err_flag);
    end
`endif
    checks++;
    if (model_mem[0] !== 32'h00000081 || model_mem[1] !== 32'h0000018B ||
        model_mem[2] !== 32'hFFFFFBB5 || model_mem[12] !== 32'hFFFFF65D) begin
      errors++;
      $display("FAIL nominal_table: got %h %h %h %h, expected 00000081 0000018b fffffbb5 fffff65d",
               model_mem[0], model_mem[1], model_mem[2], model_mem[12]);
    end
    read_all();
  endtask

  task automatic test_read_latency();
    issue_read(15);
    step();
    checks++;
    if (rd_data !== 32'hFFFFFF52) begin
      errors++;
      $display("FAIL read_addr15_const: got %h, expected ffffff52", rd_data);
    end
    step();
    checks++;
    if (rd_valid !== 1'b0 || rd_data !== 32'hFFFFFF52) begin
      errors++;
      $display("FAIL read_hold: got valid=%b data=%h, expected 0/ffffff52", rd_valid, rd_data);
    end
    issue_read(16);
    step();
    issue_read(31);
    step();
    step();
  endtask

  task automatic test_backpressure();
    load_layer(7, 1'b1, -1);
    read_all();
    bias_valid = 1'b1;
    bias_last  = 1'b0;
    bias_data  = 64'hDEAD_BEEF_CAFE_F00D;
    for (int i = 0; i < 4; i++) begin
      step();
      check_flags("valid_after_done", 1'b0, 1'b1);
    end
    bias_valid = 1'b0;
    read_all();
  endtask

  task automatic test_early_last();
    for (int i = 0; i < BIAS_NUM; i++) stage[i] = set_b[i];
    load_layer(3, 1'b0, -1);
`ifdef BIAS_RX_CHK_EN
    checks++;
    if (err_flag !== 1'b1) begin
      errors++;
      $display("FAIL err_early_last: got %b, expected 1", err_flag);
    end
`endif
    read_all();
  endtask

  task automatic test_reload_hazard();
    for (int i = 0; i < BIAS_NUM; i++) stage[i] = set_c[i];
    load_layer(7, 1'b0, 2);
    read_all();
  endtask

  task automatic test_reset_mid_load();
    for (int i = 0; i < BIAS_NUM; i++) stage[i] = set_a[i];
    load_start = 1'b1;
    step();
    issue_read(15);
    for (int k = 0; k < 4; k++) begin
      bias_valid = 1'b1;
      bias_last  = 1'b0;
      bias_data  = {stage[2*k+1], stage[2*k]};
      model_mem[2*k]   = stage[2*k];
      model_mem[2*k+1] = stage[2*k+1];
      step();
    end
    bias_valid = 1'b0;
    s_rst_n = 1'b0;
    #1;
    for (int i = 0; i < BIAS_NUM; i++) model_mem[i] = 32'd0;
    check_flags("mid_load_reset", 1'b0, 1'b0);
    checks++;
    if (rd_valid !== 1'b0 || rd_data !== 32'd0) begin
      errors++;
      $display("FAIL mid_load_reset_read: got valid=%b data=%h, expected 0/0", rd_valid, rd_data);
    end
    step();
    s_rst_n = 1'b1;
    step();
    check_flags("after_reset_idle", 1'b0, 1'b0);
    read_all();
  endtask

  initial begin
    for (int i = 0; i < BIAS_NUM; i++) begin
      set_a[i] = 32'(i * 1000 - 5000);
      set_b[i] = 32'h1000_0000 + 32'(i);
      set_c[i] = 32'hC0DE_0000 | 32'(i);
    end
    set_a[0]  = 32'h0000_0081;
    set_a[1]  = 32'h0000_018B;
    set_a[2]  = 32'(-1099);
    set_a[12] = 32'(-2467);
    set_a[15] = 32'(-174);

    test_reset();
    test_nominal();
    test_read_latency();
    test_backpressure();
    test_early_last();
    test_reload_hazard();
    test_reset_mid_load();

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending reads, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
